// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO controller state type and sizing helpers
package fifo_pkg;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_t;
  function automatic int fifo_cap(input int depth);
    return 1 << depth;
  endfunction
  function automatic int fifo_ptr_w(input int depth);
    return depth + 1;
  endfunction
endpackage

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: client requests, RAM sequencing and status bundle of the FIFO controller
interface fifo_ctrl_if #(parameter int DEPTH = 8);
  import fifo_pkg::*;
  logic push;
  logic pop;
  logic flush;
  logic ram_wr_ena;
  logic ram_valid_write;
  logic [DEPTH-1:0] ram_wr_adb;
  logic ram_rd_ena;
  logic [DEPTH-1:0] ram_rd_adb;
  logic [fifo_ptr_w(DEPTH)-1:0] count;
  logic empty;
  logic full;
  logic overflow;
  logic underflow;
  logic almost_full;
  logic almost_empty;
  modport master (
    output push, pop, flush,
    input ram_wr_ena, ram_valid_write, ram_wr_adb, ram_rd_ena, ram_rd_adb,
    input count, empty, full, overflow, underflow, almost_full, almost_empty
  );
  modport slave (
    input push, pop, flush,
    output ram_wr_ena, ram_valid_write, ram_wr_adb, ram_rd_ena, ram_rd_adb,
    output count, empty, full, overflow, underflow, almost_full, almost_empty
  );
endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping FIFO pointer, top bit flips on every pass through the RAM
module fifo_ptr #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);
  // clear beats increment; binary overflow of the full width gives the wrap flag for free
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + W'(1);
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO RAM sequencer (pointers, count, flags); define FIFO_CTRL_WATERMARK_EN for almost_full/almost_empty
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 2**DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic       clk,
  input logic       rst,
  fifo_ctrl_if.slave bus
);
  localparam int PW = fifo_ptr_w(DEPTH);
  localparam logic [PW-1:0] CAP = PW'(fifo_cap(DEPTH));
  fifo_state_t state, state_nx;
  logic [PW-1:0] wr_ptr, rd_ptr, count_q, count_nx;
  logic push_acc, pop_acc, overflow_q, underflow_q, ptr_full, ptr_empty;
  assign pop_acc  = bus.pop & ~bus.flush & (state != EMPTY);
  assign push_acc = bus.push & ~bus.flush & ((state != FULL) | pop_acc);
  assign count_nx = bus.flush ? '0 : count_q + PW'(push_acc) - PW'(pop_acc);
  fifo_ptr #(.W(PW)) u_wr_ptr (.clk(clk), .rst(rst), .inc(push_acc), .clr(bus.flush), .ptr(wr_ptr));
  fifo_ptr #(.W(PW)) u_rd_ptr (.clk(clk), .rst(rst), .inc(pop_acc), .clr(bus.flush), .ptr(rd_ptr));
  // next occupancy state; a simultaneous push and pop leaves FULL untouched
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   state_nx = push_acc ? PARTIAL : EMPTY;
      PARTIAL: state_nx = (count_nx == CAP) ? FULL : (count_nx == '0) ? EMPTY : PARTIAL;
      FULL:    state_nx = bus.flush ? EMPTY : (pop_acc & ~push_acc) ? PARTIAL : FULL;
      default: state_nx = EMPTY;
    endcase
  end
  // occupancy state and count registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= EMPTY;
      count_q <= '0;
    end else begin
      state   <= state_nx;
      count_q <= count_nx;
    end
  // sticky rejection flags, cleared only by flush or reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (bus.push & ~push_acc);
      underflow_q <= underflow_q | (bus.pop & ~pop_acc);
    end
  assign bus.ram_wr_ena      = ~push_acc;
  assign bus.ram_valid_write = push_acc;
  assign bus.ram_wr_adb      = wr_ptr[DEPTH-1:0];
  assign bus.ram_rd_ena      = (state == EMPTY);
  assign bus.ram_rd_adb      = rd_ptr[DEPTH-1:0];
  assign bus.count           = count_q;
  assign bus.empty           = (state == EMPTY);
  assign bus.full            = (state == FULL);
  assign bus.overflow        = overflow_q;
  assign bus.underflow       = underflow_q;
  assign ptr_empty = (wr_ptr == rd_ptr);
  assign ptr_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {DEPTH{1'b0}}});
  // the state decode must always agree with the pointer relationship and the count
  assert property (@(posedge clk) disable iff (rst)
    (bus.full == ptr_full) && (bus.empty == ptr_empty) && (count_q == wr_ptr - rd_ptr));
`ifdef FIFO_CTRL_WATERMARK_EN
  localparam logic [PW-1:0] AF = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE = PW'(AE_THRESH);
  logic almost_full_q, almost_empty_q;
  // watermarks track the next count so they line up with count itself
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_nx >= AF);
      almost_empty_q <= (count_nx <= AE);
    end
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
`else
  localparam int unused_thresh = AF_THRESH + AE_THRESH;
  assign bus.almost_full  = 1'b0;
  assign bus.almost_empty = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: table vectors, corner sequences and random traffic against a queue-style model
module tb_fifo_ctrl;
  localparam int D = 3;
  localparam int CAP = 8;
  typedef struct {
    bit push, pop, flush;
    int wr_adb, rd_adb, count;
    bit empty, full, ovf, unf;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_ctrl_if #(.DEPTH(D)) bus ();
  fifo_ctrl #(.DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int m_count, m_wr, m_rd;
  bit m_ovf, m_unf;
  int s_wr_adb, s_rd_adb, s_valid;
  vec_t vt[$];

  function automatic vec_t mk(bit p, bit q, bit f, int wa, int ra, int c, bit e, bit fu, bit o, bit u);
    vec_t v;
    v.push = p; v.pop = q; v.flush = f;
    v.wr_adb = wa; v.rd_adb = ra; v.count = c;
    v.empty = e; v.full = fu; v.ovf = o; v.unf = u;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, " count"}, bus.count, m_count);
    chk({tag, " empty"}, bus.empty, m_count == 0);
    chk({tag, " full"}, bus.full, m_count == CAP);
    chk({tag, " overflow"}, bus.overflow, m_ovf);
    chk({tag, " underflow"}, bus.underflow, m_unf);
`ifdef FIFO_CTRL_WATERMARK_EN
    chk({tag, " almost_full"}, bus.almost_full, m_count >= CAP - 2);
    chk({tag, " almost_empty"}, bus.almost_empty, m_count <= 2);
`else
    chk({tag, " almost_full"}, bus.almost_full, 0);
    chk({tag, " almost_empty"}, bus.almost_empty, 0);
`endif
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " ram_wr_ena"}, bus.ram_wr_ena, 1);
    chk({tag, " ram_valid_write"}, bus.ram_valid_write, 0);
    chk({tag, " ram_rd_ena"}, bus.ram_rd_ena, 1);
    chk({tag, " ram_wr_adb"}, bus.ram_wr_adb, 0);
    chk({tag, " ram_rd_adb"}, bus.ram_rd_adb, 0);
    check_status(tag);
  endtask

  // one clock of traffic, entered and left just after a falling edge
  task automatic step(input bit p, input bit q, input bit f);
    bit pa, wa;
    bus.push = p; bus.pop = q; bus.flush = f;
    pa = q && !f && m_count > 0;
    wa = p && !f && (m_count < CAP || pa);
    #1;
    s_wr_adb = bus.ram_wr_adb;
    s_rd_adb = bus.ram_rd_adb;
    s_valid  = bus.ram_valid_write;
    chk("ram_wr_ena", bus.ram_wr_ena, !wa);
    chk("ram_valid_write", bus.ram_valid_write, wa);
    chk("ram_wr_adb", bus.ram_wr_adb, m_wr);
    chk("ram_rd_ena", bus.ram_rd_ena, m_count == 0);
    chk("ram_rd_adb", bus.ram_rd_adb, m_rd);
    @(posedge clk);
    #1;
    if (f) model_reset();
    else begin
      if (p && !wa) m_ovf = 1;
      if (q && !pa) m_unf = 1;
      m_count += int'(wa) - int'(pa);
      m_wr = (m_wr + int'(wa)) % CAP;
      m_rd = (m_rd + int'(pa)) % CAP;
    end
    check_status("post");
    @(negedge clk);
    bus.push = 0; bus.pop = 0; bus.flush = 0;
  endtask

  initial begin
    int bias;
    bus.push = 0; bus.pop = 0; bus.flush = 0;
    model_reset();
    for (int i = 0; i < 9; i++)
      vt.push_back(mk(1, 0, 0, i % 8, 0, (i < 8) ? i + 1 : 8, 0, i >= 7, i == 8, 0));
    for (int j = 0; j < 9; j++)
      vt.push_back(mk(0, 1, 0, 0, j % 8, (j < 8) ? 7 - j : 0, j >= 7, 0, 1, j == 8));
    vt.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 5; k++) vt.push_back(mk(1, 0, 0, k, 0, k + 1, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) vt.push_back(mk(0, 1, 0, 5, k, 4 - k, k == 4, 0, 0, 0));
    for (int k = 0; k < 6; k++) vt.push_back(mk(1, 0, 0, (5 + k) % 8, 5, k + 1, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 0;
    foreach (vt[n]) begin
      step(vt[n].push, vt[n].pop, vt[n].flush);
      if (vt[n].push) chk("tbl wr_adb", s_wr_adb, vt[n].wr_adb);
      if (vt[n].pop) chk("tbl rd_adb", s_rd_adb, vt[n].rd_adb);
      chk("tbl count", bus.count, vt[n].count);
      chk("tbl empty", bus.empty, vt[n].empty);
      chk("tbl full", bus.full, vt[n].full);
      chk("tbl overflow", bus.overflow, vt[n].ovf);
      chk("tbl underflow", bus.underflow, vt[n].unf);
      chk("tbl rd_ena", bus.ram_rd_ena, vt[n].empty);
    end
    chk("wrap rd_adb", bus.ram_rd_adb, 5);
    chk("wrap wr_adb", bus.ram_wr_adb, 3);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("fill full", bus.full, 1);
    step(1, 1, 0);
    chk("full pp valid", s_valid, 1);
    chk("full pp wr_adb", s_wr_adb, 5);
    chk("full pp rd_adb", s_rd_adb, 5);
    chk("full pp count", bus.count, 8);
    chk("full pp ovf", bus.overflow, 0);
    chk("full pp rd_adb next", bus.ram_rd_adb, 6);
    step(0, 0, 1);
    step(1, 1, 0);
    chk("empty pp count", bus.count, 1);
    chk("empty pp unf", bus.underflow, 1);
    chk("empty pp empty", bus.empty, 0);
    step(0, 0, 1);
    chk("flush count", bus.count, 0);
    chk("flush unf", bus.underflow, 0);
    chk("flush ovf", bus.overflow, 0);
    repeat (4) step(1, 0, 0);
    chk("pre rst count", bus.count, 4);
    rst = 1;
    #1;
    model_reset();
    check_reset("midrst");
    @(negedge clk);
    rst = 0;
    for (int blk = 0; blk < 20; blk++) begin
      bias = (blk % 2 == 0) ? 75 : 25;
      for (int c = 0; c < 80; c++)
        step($urandom_range(0, 99) < bias, $urandom_range(0, 99) < 100 - bias, $urandom_range(0, 63) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
